// File: rtl/serial_sub_nbit.sv
// serial_sub_nbit: multi-cycle N-bit subtractor, diff = a - b - bin, STEP bits per clock LSB first.
// Operands enter through in_valid/in_ready and results leave through out_valid/out_ready.
// Optional macro SERIAL_SUB_OVF_EN adds the ovf output (two's-complement signed overflow).
module serial_sub_nbit #(
    parameter int unsigned N    = 4,
    parameter int unsigned STEP = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         bout
`ifdef SERIAL_SUB_OVF_EN
   ,output logic         ovf
`endif
);

    localparam int unsigned NSTEPS = N / STEP;
    localparam int unsigned CW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
    localparam int unsigned SW     = STEP + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Reject parameter combinations that cannot be sliced evenly.
    if (N < 1 || STEP < 1 || (N % STEP) != 0) begin : g_param_check
        $error("serial_sub_nbit: need N >= 1, STEP >= 1 and N %% STEP == 0");
    end

    logic [1:0]    state_q,     state_d;
    logic [N-1:0]  a_q,         a_d;
    logic [N-1:0]  b_q,         b_d;
    logic [N-1:0]  diff_q,      diff_d;
    logic          borrow_q,    borrow_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic          bout_q,      bout_d;
    logic          in_ready_q,  in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [SW-1:0] sub;
    logic          last;
`ifdef SERIAL_SUB_OVF_EN
    logic          a_sgn_q,     a_sgn_d;
    logic          b_sgn_q,     b_sgn_d;
    logic          ovf_q,       ovf_d;
`endif

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        diff_d      = diff_q;
        borrow_d    = borrow_q;
        cnt_d       = cnt_q;
        bout_d      = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        a_sgn_d     = a_sgn_q;
        b_sgn_d     = b_sgn_q;
        ovf_d       = ovf_q;
`endif
        // {borrow_next, slice} = a_slice - b_slice - borrow, in STEP+1 bits
        sub  = {1'b0, a_q[STEP-1:0]} - {1'b0, b_q[STEP-1:0]} - SW'(borrow_q);
        last = (cnt_q == CW'(NSTEPS - 1));

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    cnt_d    = '0;
`ifdef SERIAL_SUB_OVF_EN
                    a_sgn_d  = a[N-1];
                    b_sgn_d  = b[N-1];
`endif
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                a_d      = a_q >> STEP;
                b_d      = b_q >> STEP;
                diff_d   = (diff_q >> STEP) | (N'(sub[STEP-1:0]) << (N - STEP));
                borrow_d = sub[STEP];
                cnt_d    = cnt_q + CW'(1);
                if (last) begin
                    bout_d  = sub[STEP];
`ifdef SERIAL_SUB_OVF_EN
                    // Overflow only when operand signs differ and the result sign disagrees with a.
                    ovf_d   = (a_sgn_q != b_sgn_q) && (sub[STEP-1] != a_sgn_q);
`endif
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            cnt_q       <= '0;
            bout_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_sgn_q     <= 1'b0;
            b_sgn_q     <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            diff_q      <= diff_d;
            borrow_q    <= borrow_d;
            cnt_q       <= cnt_d;
            bout_q      <= bout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef SERIAL_SUB_OVF_EN
            a_sgn_q     <= a_sgn_d;
            b_sgn_q     <= b_sgn_d;
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub_nbit.sv
// Bench for serial_sub_nbit: an N=4/STEP=1 and an N=8/STEP=4 instance checked against a
// scoreboard of expected results; ovf is checked when SERIAL_SUB_OVF_EN is defined.
module tb_serial_sub_nbit;

    typedef struct packed {
        logic [7:0] diff;
        logic       bout;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       iv4, ir4, bin4, ov4, or4, bo4, ovf4;
    logic [3:0] a4, b4, d4;
    logic       iv8, ir8, bin8, ov8, or8, bo8, ovf8;
    logic [7:0] a8, b8, d8;

    exp_t q4[$];
    exp_t q8[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    serial_sub_nbit #(.N(4), .STEP(1)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .bin(bin4),
        .out_valid(ov4), .out_ready(or4), .diff(d4), .bout(bo4)
`ifdef SERIAL_SUB_OVF_EN
       ,.ovf(ovf4)
`endif
    );

    serial_sub_nbit #(.N(8), .STEP(4)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .bin(bin8),
        .out_valid(ov8), .out_ready(or8), .diff(d8), .bout(bo8)
`ifdef SERIAL_SUB_OVF_EN
       ,.ovf(ovf8)
`endif
    );

`ifndef SERIAL_SUB_OVF_EN
    assign ovf4 = 1'b0;
    assign ovf8 = 1'b0;
`endif

    // Reference: plain integer arithmetic on the full operands.
    function automatic exp_t model(input int n, input int a, input int b, input int bi);
        exp_t e;
        int   r, sa, sb, s, half;
        half   = 1 << (n - 1);
        r      = a - b - bi;
        e.diff = 8'(r & ((1 << n) - 1));
        e.bout = (r < 0);
        sa     = (a >= half) ? a - (1 << n) : a;
        sb     = (b >= half) ? b - (1 << n) : b;
        s      = sa - sb - bi;
        e.ovf  = (s < -half) || (s > half - 1);
        return e;
    endfunction

    task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic bi);
        int w = 0;
        while (!ir4 && w < 30) begin @(negedge clk); w++; end
        if (!ir4) begin
            n_checks++; n_fail++;
            $display("FAIL send4_ready in_ready=%b required 1", ir4);
            return;
        end
        a4 = a; b4 = b; bin4 = bi; iv4 = 1'b1;
        q4.push_back(model(4, int'(a), int'(b), int'(bi)));
        @(negedge clk);
        iv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
    endtask

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic bi);
        int w = 0;
        while (!ir8 && w < 30) begin @(negedge clk); w++; end
        if (!ir8) begin
            n_checks++; n_fail++;
            $display("FAIL send8_ready in_ready=%b required 1", ir8);
            return;
        end
        a8 = a; b8 = b; bin8 = bi; iv8 = 1'b1;
        q8.push_back(model(8, int'(a), int'(b), int'(bi)));
        @(negedge clk);
        iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    endtask

    // Wait for out_valid (lat = expected negedges after the accepting edge, -1 skips), compare, accept.
    task automatic recv4(input string name, input int lat);
        exp_t e;
        int   w = 0;
        while (!ov4 && w < 40) begin @(negedge clk); w++; end
        n_checks++;
        if (!ov4 || (lat >= 0 && w != lat)) begin
            n_fail++;
            $display("FAIL %s_latency out_valid=%b after %0d cycles required 1 after %0d", name, ov4, w, lat);
            if (!ov4) return;
        end
        if (q4.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL %s_sb unexpected result diff=%0d required none", name, d4);
        end else begin
            e = q4.pop_front();
            n_checks++;
            if (d4 !== e.diff[3:0] || bo4 !== e.bout) begin
                n_fail++;
                $display("FAIL %s diff=%0d bout=%b required diff=%0d bout=%b", name, d4, bo4, e.diff[3:0], e.bout);
            end
`ifdef SERIAL_SUB_OVF_EN
            n_checks++;
            if (ovf4 !== e.ovf) begin
                n_fail++;
                $display("FAIL %s_ovf ovf=%b required %b", name, ovf4, e.ovf);
            end
`endif
        end
        or4 = 1'b1;
        @(negedge clk);
        or4 = 1'b0;
    endtask

    task automatic recv8(input string name, input int lat);
        exp_t e;
        int   w = 0;
        while (!ov8 && w < 40) begin @(negedge clk); w++; end
        n_checks++;
        if (!ov8 || (lat >= 0 && w != lat)) begin
            n_fail++;
            $display("FAIL %s_latency out_valid=%b after %0d cycles required 1 after %0d", name, ov8, w, lat);
            if (!ov8) return;
        end
        if (q8.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL %s_sb unexpected result diff=%0d required none", name, d8);
        end else begin
            e = q8.pop_front();
            n_checks++;
            if (d8 !== e.diff || bo8 !== e.bout) begin
                n_fail++;
                $display("FAIL %s diff=%0h bout=%b required diff=%0h bout=%b", name, d8, bo8, e.diff, e.bout);
            end
`ifdef SERIAL_SUB_OVF_EN
            n_checks++;
            if (ovf8 !== e.ovf) begin
                n_fail++;
                $display("FAIL %s_ovf ovf=%b required %b", name, ovf8, e.ovf);
            end
`endif
        end
        or8 = 1'b1;
        @(negedge clk);
        or8 = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        iv4 = 0; a4 = 0; b4 = 0; bin4 = 0; or4 = 0;
        iv8 = 0; a8 = 0; b8 = 0; bin8 = 0; or8 = 0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (ir4 !== 1'b0 || ov4 !== 1'b0 || d4 !== 4'd0 || bo4 !== 1'b0 || ovf4 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset4 in_ready=%b out_valid=%b diff=%0d bout=%b ovf=%b required all 0", ir4, ov4, d4, bo4, ovf4);
        end
        n_checks++;
        if (ir8 !== 1'b0 || ov8 !== 1'b0 || d8 !== 8'd0 || bo8 !== 1'b0 || ovf8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset8 in_ready=%b out_valid=%b diff=%0d bout=%b ovf=%b required all 0", ir8, ov8, d8, bo8, ovf8);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ir4 !== 1'b1 || ir8 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release in_ready4=%b in_ready8=%b required 1 1", ir4, ir8);
        end
    endtask

    // Counting the accepting edge, out_valid rises on the fifth edge for N=4, STEP=1.
    task automatic test_basic;
        send4(4'd5, 4'd3, 1'b0);  recv4("sub_5_3", 4);
        send4(4'd3, 4'd5, 1'b0);  recv4("sub_3_5", 4);
        send4(4'd0, 4'd0, 1'b1);  recv4("sub_0_0_bin", 4);
        send4(4'd0, 4'd15, 1'b1); recv4("wrap_0_15_bin", 4);
        send4(4'd15, 4'd0, 1'b0); recv4("sub_15_0", 4);
    endtask

    task automatic test_backpressure;
        logic [3:0] d_ref;
        logic       bo_ref;
        int         w = 0;
        send4(4'd7, 4'd2, 1'b1);
        while (!ov4 && w < 40) begin @(negedge clk); w++; end
        d_ref = d4; bo_ref = bo4;
        a4 = 4'd1; b4 = 4'd1; bin4 = 1'b0; iv4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (ov4 !== 1'b1 || ir4 !== 1'b0 || d4 !== d_ref || bo4 !== bo_ref) begin
                n_fail++;
                $display("FAIL hold_%0d out_valid=%b in_ready=%b diff=%0d bout=%b required 1 0 %0d %b",
                         i, ov4, ir4, d4, bo4, d_ref, bo_ref);
            end
        end
        recv4("held_result", -1);
        n_checks++;
        if (ir4 !== 1'b1 || ov4 !== 1'b0) begin
            n_fail++;
            $display("FAIL after_accept in_ready=%b out_valid=%b required 1 0", ir4, ov4);
        end
        q4.push_back(model(4, 1, 1, 0));
        @(negedge clk);
        iv4 = 1'b0;
        recv4("next_after_hold", 4);
    endtask

    task automatic test_reset_mid;
        exp_t dropped;
        int   seen = 0;
        send4(4'd9, 4'd2, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        dropped = q4.pop_back();
        n_checks++;
        if (ov4 !== 1'b0 || d4 !== 4'd0 || bo4 !== 1'b0 || ir4 !== 1'b0 || ovf4 !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset out_valid=%b diff=%0d bout=%b in_ready=%b ovf=%b required all 0 (dropped %0d)",
                     ov4, d4, bo4, ir4, ovf4, dropped.diff);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ov4 !== 1'b0) seen++;
        end
        n_checks++;
        if (seen != 0 || ir4 !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_release out_valid_cycles=%0d in_ready=%b required 0 1", seen, ir4);
        end
        send4(4'd9, 4'd2, 1'b0); recv4("fresh_9_2", 4);
    endtask

    task automatic test_step4;
        send8(8'h00, 8'h01, 1'b0); recv8("n8_0_1", 2);
        send8(8'h00, 8'hFF, 1'b1); recv8("n8_0_ff_bin", 2);
        send8(8'hA5, 8'h5A, 1'b1); recv8("n8_a5_5a", 2);
        for (int i = 0; i < 6; i++) begin
            send8(8'($urandom), 8'($urandom), 1'($urandom));
            recv8("n8_rand", 2);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 10; i++) begin
            send4(4'($urandom), 4'($urandom), 1'($urandom));
            recv4("b2b_rand", 4);
        end
    endtask

`ifdef SERIAL_SUB_OVF_EN
    task automatic test_ovf;
        send4(4'd8, 4'd1, 1'b0);  recv4("ovf_8_1", 4);
        send4(4'd7, 4'd15, 1'b0); recv4("ovf_7_15", 4);
        send4(4'd6, 4'd2, 1'b0);  recv4("ovf_6_2", 4);
        send8(8'h80, 8'h00, 1'b1); recv8("ovf8_80_bin", 2);
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_reset_mid;
        test_step4;
        test_back_to_back;
`ifdef SERIAL_SUB_OVF_EN
        test_ovf;
`endif
        n_checks++;
        if (q4.size() != 0 || q8.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain left4=%0d left8=%0d required 0 0", q4.size(), q8.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
